tr_step_monitor: RTL and testbench

- Receiver end of the stepper drive interface: consumes drv_step / drv_dir / drv_enable_SM as produced by the tracking controller and its pulse generator.
- Keeps a signed motor position count and measures the step period in clk cycles, in the same units as the controller's N.
- Checks pulse-width and direction-setup timing.
- Sits beside the drive outputs as closed-loop position feedback and as a bench/hardware checker.

---
 rtl/tr_pkg.sv | 21 ++
 rtl/tr_edge_sync.sv | 34 +++
 rtl/tr_step_monitor.sv | 121 ++++++++++++
 tb/tb_tr_step_monitor.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/tr_pkg.sv
// Shared types and constants for the stepper tracking controller and its monitors.
package tr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    TRACK = 2'd2
  } tr_state_t;

  localparam int unsigned ERR_SHORT  = 0;
  localparam int unsigned ERR_DIR    = 1;
  localparam int unsigned ERR_DIS    = 2;
  localparam int unsigned ERR_W      = 3;
  localparam int unsigned TR_PER_W   = 17;
  localparam int unsigned SYNC_CNT_W = 8;

  function automatic logic [SYNC_CNT_W-1:0] sat_inc(input logic [SYNC_CNT_W-1:0] v);
    return (v == '1) ? v : v + SYNC_CNT_W'(1);
  endfunction

endpackage

// File: rtl/tr_edge_sync.sv
// Registers a 1-bit input; reports level, edges and a saturating cycles-since-change count.
module tr_edge_sync
  import tr_pkg::*;
#(
  parameter logic INIT = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  d,
  output logic                  level,
  output logic                  rise_c,
  output logic                  fall_c,
  output logic [SYNC_CNT_W-1:0] stable
);

  logic prev;

  // prev resets equal to level so the first sampled value cannot fake an edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      level  <= INIT;
      prev   <= INIT;
      stable <= '1;
    end else begin
      prev   <= level;
      level  <= d;
      stable <= (d != level) ? '0 : sat_inc(stable);
    end
  end

  assign rise_c = level & ~prev;
  assign fall_c = ~level & prev;

endmodule

// File: rtl/tr_step_monitor.sv
// Stepper drive receiver: position count, step period measurement and timing checks.
module tr_step_monitor
  import tr_pkg::*;
#(
  parameter int unsigned POS_W     = 32,
  parameter int unsigned PER_W     = TR_PER_W,
  parameter int unsigned MIN_HIGH  = 2,
  parameter int unsigned DIR_SETUP = 2,
  parameter int unsigned TIMEOUT   = 100000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    drv_step,
  input  logic                    drv_dir,
  input  logic                    drv_enable_SM,
  input  logic                    pos_clear,
  input  logic                    err_clr,
  output logic signed [POS_W-1:0] position,
  output logic        [PER_W-1:0] period,
  output logic                    period_valid,
  output logic                    moving,
  output logic        [ERR_W-1:0] step_err
);

  logic                  step_q, step_rise, step_fall;
  logic                  dir_q, dir_rise, dir_fall;
  logic [SYNC_CNT_W-1:0] step_stable, dir_stable, high_cnt;
  logic                  en_q;
  logic [PER_W-1:0]      cnt;
  tr_state_t             state;
  logic                  accept_c;
  logic                  dir_bad_c;
  logic [ERR_W-1:0]      new_err_c;

  tr_edge_sync #(.INIT(1'b1)) u_step_sync (
    .clk    (clk),
    .rst    (rst),
    .d      (drv_step),
    .level  (step_q),
    .rise_c (step_rise),
    .fall_c (step_fall),
    .stable (step_stable)
  );

  tr_edge_sync #(.INIT(1'b0)) u_dir_sync (
    .clk    (clk),
    .rst    (rst),
    .d      (drv_dir),
    .level  (dir_q),
    .rise_c (dir_rise),
    .fall_c (dir_fall),
    .stable (dir_stable)
  );

  assign accept_c  = step_rise && (state != IDLE);
  assign dir_bad_c = dir_rise | dir_fall | (32'(dir_stable) < DIR_SETUP);

  always_comb begin
    new_err_c            = '0;
    new_err_c[ERR_SHORT] = step_fall && (32'(high_cnt) < MIN_HIGH);
    new_err_c[ERR_DIR]   = step_rise && dir_bad_c;
    new_err_c[ERR_DIS]   = step_rise && (state == IDLE);
  end

  // high_cnt resets saturated so a pulse straddling reset never reads as short
  always_ff @(posedge clk) begin
    if (!rst) begin
      en_q         <= 1'b0;
      high_cnt     <= '1;
      cnt          <= '0;
      state        <= IDLE;
      position     <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      moving       <= 1'b0;
      step_err     <= '0;
    end else begin
      en_q         <= drv_enable_SM;
      period_valid <= 1'b0;
      if (step_q) high_cnt <= sat_inc(step_stable);
      step_err <= (err_clr ? '0 : step_err) | new_err_c;

      if (pos_clear)     position <= '0;
      else if (accept_c) position <= dir_q ? position + POS_W'(1) : position - POS_W'(1);

      if (state == IDLE)  cnt <= '0;
      else if (accept_c)  cnt <= PER_W'(1);
      else if (cnt != '1) cnt <= cnt + PER_W'(1);

      if (accept_c && state == TRACK) begin
        period       <= cnt;
        period_valid <= 1'b1;
      end

      case (state)
        IDLE: if (en_q) state <= ARMED;
        ARMED: begin
          if (!en_q) state <= IDLE;
          else if (accept_c) begin
            state  <= TRACK;
            moving <= 1'b1;
          end
        end
        TRACK: begin
          if (!en_q) begin
            state  <= IDLE;
            moving <= 1'b0;
          end else if (!accept_c && 32'(cnt) == TIMEOUT) begin
            state  <= ARMED;
            moving <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          moving <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tr_step_monitor.sv
// Scoreboard bench for tr_step_monitor; a second instance with a narrow period counter covers saturation.
module tb_tr_step_monitor;

  localparam int unsigned POS_W    = 8;
  localparam int unsigned PER_W    = 12;
  localparam int unsigned TIMEOUT  = 1000;
  localparam int unsigned PER_W_S  = 8;
  localparam int          PER_MAX  = 4095;
  localparam int          MIN_HIGH = 2;
  localparam int          DIR_SET  = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic drv_step = 1'b0, drv_dir = 1'b1, drv_enable_SM = 1'b1;
  logic pos_clear = 1'b0, err_clr = 1'b0;

  logic signed [POS_W-1:0] position, position_s;
  logic [PER_W-1:0]        period;
  logic [PER_W_S-1:0]      period_s;
  logic                    period_valid, pv_s, moving, moving_s;
  logic [2:0]              step_err, step_err_s;

  always #10 clk = ~clk;

  tr_step_monitor #(.POS_W(POS_W), .PER_W(PER_W), .MIN_HIGH(2), .DIR_SETUP(2), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .drv_step(drv_step), .drv_dir(drv_dir), .drv_enable_SM(drv_enable_SM),
    .pos_clear(pos_clear), .err_clr(err_clr), .position(position), .period(period),
    .period_valid(period_valid), .moving(moving), .step_err(step_err));

  tr_step_monitor #(.POS_W(POS_W), .PER_W(PER_W_S), .MIN_HIGH(2), .DIR_SETUP(2), .TIMEOUT(100000)) dut_sat (
    .clk(clk), .rst(rst), .drv_step(drv_step), .drv_dir(drv_dir), .drv_enable_SM(drv_enable_SM),
    .pos_clear(pos_clear), .err_clr(err_clr), .position(position_s), .period(period_s),
    .period_valid(pv_s), .moving(moving_s), .step_err(step_err_s));

  int n_checks = 0, n_pass = 0;
  int cyc = 0, pv_count = 0;
  int exp_q[$];
  logic signed [POS_W-1:0] exp_pos = '0;
  logic [2:0] exp_err = '0;
  logic model_en = 1'b1, ref_ok = 1'b0, model_dir = 1'b1;
  int last_rise = 0, dir_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst && period_valid) begin
      pv_count++;
      if (exp_q.size() == 0) check("period_unexpected", 32'(period), 32'hFFFF_FFFF);
      else check("period", 32'(period), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_dir(input logic v);
    drv_dir = v; model_dir = v; dir_cyc = cyc;
  endtask

  task automatic set_en(input logic v);
    drv_enable_SM = v;
    tick(3);
    model_en = v;
    if (!v) ref_ok = 1'b0;
  endtask

  task automatic clear_pos();
    pos_clear = 1'b1; tick(1); pos_clear = 1'b0; exp_pos = '0;
  endtask

  task automatic clear_err();
    err_clr = 1'b1; tick(1); err_clr = 1'b0; exp_err = '0;
  endtask

  task automatic pulse(input int high, input int low, input logic clr);
    int now = cyc;
    int gap = now - last_rise;
    if (high < MIN_HIGH) exp_err[0] = 1'b1;
    if (now - dir_cyc < DIR_SET) exp_err[1] = 1'b1;
    if (!model_en) exp_err[2] = 1'b1;
    else begin
      if (ref_ok && gap <= int'(TIMEOUT)) exp_q.push_back(gap > PER_MAX ? PER_MAX : gap);
      ref_ok = 1'b1;
      last_rise = now;
      if (clr) exp_pos = '0;
      else exp_pos = exp_pos + (model_dir ? 8'sd1 : -8'sd1);
    end
    drv_step = 1'b1;
    if (clr) begin
      tick(1); pos_clear = 1'b1; tick(1); pos_clear = 1'b0; tick(high - 2);
    end else tick(high);
    drv_step = 1'b0;
    tick(low);
  endtask

  initial begin
    int pv0, last, fell;
    repeat (5) begin
      @(negedge clk);
      drv_step = ~drv_step;
      check("rst_pv", 32'(period_valid | pv_s), 0);
    end
    check("rst_position", 32'(position), 0);
    check("rst_period", 32'(period), 0);
    check("rst_moving", 32'(moving | moving_s), 0);
    check("rst_step_err", 32'(step_err), 0);

    // release with drv_step still high: no step may be counted
    rst = 1'b1;
    tick(10);
    check("midpulse_pos", 32'(position), 0);
    drv_step = 1'b0;
    tick(20);
    check("midpulse_err", 32'(step_err), 0);

    pv0 = pv_count;
    repeat (10) pulse(4, 96, 1'b0);
    check("fwd_position", 32'(position), 32'(exp_pos));
    check("fwd_pv_count", 32'(pv_count - pv0), 9);
    check("fwd_period", 32'(period), 100);
    check("fwd_moving", 32'(moving), 1);

    clear_pos();
    repeat (4) pulse(4, 96, 1'b0);
    pulse(4, 86, 1'b0);
    set_dir(1'b0);
    tick(10);
    repeat (8) pulse(4, 96, 1'b0);
    check("rev_position", 32'(position), 32'hFFFF_FFFD);
    check("rev_err", 32'(step_err), 0);

    set_dir(1'b1);
    tick(1);
    pulse(4, 96, 1'b0);
    check("dir_setup_err", 32'(step_err), 32'(exp_err));
    check("dir_setup_pos", 32'(position), 32'(exp_pos));
    clear_err();
    check("err_clr", 32'(step_err), 0);

    pulse(1, 99, 1'b0);
    check("short_err", 32'(step_err), 32'(exp_err));
    clear_err();

    set_en(1'b0);
    check("dis_moving", 32'(moving), 0);
    pulse(4, 96, 1'b0);
    pulse(4, 96, 1'b0);
    check("dis_err", 32'(step_err), 32'(exp_err));
    check("dis_position", 32'(position), 32'(exp_pos));
    clear_err();
    set_en(1'b1);

    repeat (3) pulse(4, 96, 1'b0);
    last = last_rise;
    fell = 0;
    for (int k = 0; k < 3 * int'(TIMEOUT) && fell == 0; k++) begin
      tick(1);
      if (!moving) fell = 1;
    end
    check("timeout_fell", 32'(fell), 1);
    check("timeout_delay", 32'(cyc - (last + 2)), TIMEOUT);
    pv0 = pv_count;
    pulse(4, 96, 1'b0);
    check("rearm_no_pv", 32'(pv_count - pv0), 0);
    pulse(4, 96, 1'b0);
    check("rearm_pv", 32'(pv_count - pv0), 1);
    check("rearm_moving", 32'(moving), 1);

    pulse(4, 296, 1'b0);
    pulse(4, 10, 1'b0);
    check("period_300", 32'(period), 300);
    check("period_sat", 32'(period_s), 255);

    clear_pos();
    repeat (127) pulse(2, 4, 1'b0);
    check("pos_max", 32'(position), 32'h0000_007F);
    pulse(2, 4, 1'b0);
    check("pos_wrap", 32'(position), 32'hFFFF_FF80);

    pulse(4, 20, 1'b1);
    check("clr_with_rise", 32'(position), 0);
    pulse(4, 20, 1'b0);
    check("after_clr", 32'(position), 32'(exp_pos));
    check("final_err", 32'(step_err), 32'(exp_err));

    tick(5);
    check("queue_empty", 32'(exp_q.size()), 0);
    check("sat_position", 32'(position_s), 32'(exp_pos));
    check("sat_err", 32'(step_err_s), 32'(exp_err));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
